udl_limit_counter: RTL

- Parametrised up/down/load counter with programmable lower and upper limits, a programmable step and a selectable wrap or saturate mode.
- A built-in prescaler sets how often the count advances.
- Sticky overflow/underflow flags and a terminal-count pulse go to the timer and sequencer blocks.
- Drop-in successor to the team's fixed-width up/down/load counter in control and timing paths.

---
 rtl/udl_counter_pkg.sv | 22 ++
 rtl/udl_limit_counter_tick_prescaler.sv | 48 ++++
 rtl/udl_limit_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/udl_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : udl_counter_pkg
// Purpose : Shared constants and event encoding for the limit counter family.
// Revision: 1.0
// ============================================================================
package udl_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEFAULT_BITS = 8;
    localparam int DEFAULT_PW   = 4;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_OVF  = 2'd1,
        EV_UNF  = 2'd2
    } udl_event_e;

endpackage
`default_nettype wire

// File: rtl/udl_limit_counter_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Purpose : Enable-gated divider issuing one tick every div+1 enabled cycles.
// Revision: 1.0
// ============================================================================
module tick_prescaler
    import udl_counter_pkg::*;
#(
    parameter int PW = DEFAULT_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic [PW-1:0] div,
    input  logic          inhibit,
    output logic          tick
);

    logic [PW-1:0] pres_q;
    logic [PW-1:0] pres_d;

    always_comb begin
        tick   = enable && !clear && !inhibit && (pres_q == div);
        pres_d = pres_q;
        if (clear) begin
            pres_d = '0;
        end else if (enable && !inhibit) begin
            // pres above div (div lowered mid-count) restarts without a tick
            if (pres_q >= div) begin
                pres_d = '0;
            end else begin
                pres_d = pres_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pres_q <= '0;
        end else begin
            pres_q <= pres_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/udl_limit_counter.sv
`default_nettype none
// ============================================================================
// Module  : udl_limit_counter
// Purpose : Up/down/load counter with limits, step, wrap/saturate and flags.
// Revision: 1.0
// ============================================================================
module udl_limit_counter
    import udl_counter_pkg::*;
#(
    parameter int              BITS      = DEFAULT_BITS,
    parameter int              PW        = DEFAULT_PW,
    parameter logic [BITS-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [BITS-1:0] D,
    input  logic [BITS-1:0] step,
    input  logic [BITS-1:0] lim_lo,
    input  logic [BITS-1:0] lim_hi,
    input  logic            sat_mode,
    input  logic [PW-1:0]   div,
    input  logic            clr_flags,
    output logic [BITS-1:0] Q,
    output logic            tick,
    output logic            tc,
    output logic            ovf,
    output logic            unf,
    output logic            cfg_err
);

    logic [BITS-1:0] q_q, q_d;
    logic            tc_q, tc_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [BITS:0]   sum;
    logic [BITS-1:0] above_lo;
    logic [BITS-1:0] d_clamped;
    logic            overrun;
    logic            underrun;

    assign cfg_err = (lim_lo > lim_hi);

    tick_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .clear   (load),
        .div     (div),
        .inhibit (cfg_err),
        .tick    (tick)
    );

    // Extra carry bit keeps an overrun past 2^BITS-1 from aliasing into range
    assign sum       = {1'b0, q_q} + {1'b0, step};
    assign above_lo  = q_q - lim_lo;
    assign overrun   = (sum > {1'b0, lim_hi});
    assign underrun  = (q_q < lim_lo) || (above_lo < step);
    assign d_clamped = (D < lim_lo) ? lim_lo : ((D > lim_hi) ? lim_hi : D);

    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q && !clr_flags;
        unf_d = unf_q && !clr_flags;
        if (load) begin
            q_d = cfg_err ? D : d_clamped;
        end else if (tick) begin
            if (up) begin
                if (overrun) begin
                    q_d   = (sat_mode == MODE_SAT) ? lim_hi : lim_lo;
                    ovf_d = 1'b1;
                    tc_d  = 1'b1;
                end else begin
                    q_d = sum[BITS-1:0];
                end
            end else begin
                if (underrun) begin
                    q_d   = (sat_mode == MODE_SAT) ? lim_lo : lim_hi;
                    unf_d = 1'b1;
                    tc_d  = 1'b1;
                end else begin
                    q_d = q_q - step;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= RESET_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign Q   = q_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule
`default_nettype wire
